// File: rtl/m_store_buffer.sv
// Store buffer for the MEM stage: formats store data and byte enables and queues them for memory.
// Optional store merging into the youngest entry is enabled by defining M_SB_MERGE_EN.
module m_store_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [2:0]            st_op,
  input  logic [31:0]           st_addr,
  input  logic [DATA_W-1:0]     st_wdata,
  input  logic                  int_req,
  output logic                  st_ready,
  output logic                  st_exc,
  input  logic [31:0]           ld_addr,
  output logic                  ld_conflict,
  output logic                  m_valid,
  output logic [31:0]           m_addr,
  output logic [DATA_W/8-1:0]   m_byteen,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ready,
  output logic                  sb_empty
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [2:0] OP_SB = 3'd1;
  localparam logic [2:0] OP_SH = 3'd2;
  localparam logic [2:0] OP_SW = 3'd3;
  localparam logic [2:0] OP_SD = 3'd4;
  localparam logic [31:0] WORD_MASK = ~((32'd1 << OFF) - 32'd1);

  logic [31:0]       addr_mem [DEPTH];
  logic [NB-1:0]     be_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_reg, tail_reg, tail_m1;
  logic [CW-1:0] count_reg;
  logic [OFF-1:0] lo;
  logic op_valid, misaligned, full, deq, acc, enq, do_merge, merge_hit;
  logic [NB-1:0]     new_be;
  logic [DATA_W-1:0] new_data, merged_data;
  logic [31:0]       word_addr;
  logic [DEPTH-1:0]  hit;

  assign lo        = st_addr[OFF-1:0];
  assign word_addr = st_addr & WORD_MASK;
  assign tail_m1   = tail_reg - PW'(1);
  assign full      = (count_reg == CW'(DEPTH));
  assign m_valid   = (count_reg != '0);
  assign sb_empty  = ~m_valid;
  assign deq       = m_valid & m_ready;

  always_comb begin
    op_valid   = 1'b0;
    misaligned = 1'b0;
    new_data   = '0;
    new_be     = '0;
    case (st_op)
      OP_SB: begin
        op_valid = 1'b1;
        new_data = {NB{st_wdata[7:0]}};
        new_be   = NB'(1) << lo;
      end
      OP_SH: begin
        op_valid   = 1'b1;
        misaligned = st_addr[0];
        new_data   = {(NB/2){st_wdata[15:0]}};
        new_be     = NB'(3) << (lo & ~OFF'(1));
      end
      OP_SW: begin
        op_valid   = 1'b1;
        misaligned = (st_addr[1:0] != 2'b00);
        new_data   = {(NB/4){st_wdata[31:0]}};
        new_be     = NB'(4'hF) << (lo & ~OFF'(3));
      end
      OP_SD: begin
        // Doubleword stores exist only on a 64-bit memory port.
        op_valid   = (DATA_W == 64);
        misaligned = (st_addr[2:0] != 3'b000);
        new_data   = st_wdata;
        new_be     = '1;
      end
      default: ;
    endcase
  end

  assign st_exc = st_valid & op_valid & misaligned;

`ifdef M_SB_MERGE_EN
  // The youngest entry can absorb a store to the same word unless it is leaving this cycle.
  assign merge_hit = st_valid & op_valid & ~int_req & ~st_exc & m_valid &
                     (((addr_mem[tail_m1] ^ st_addr) & WORD_MASK) == '0) &
                     (~deq | (count_reg >= CW'(2)));
  assign st_ready  = ~full | merge_hit;
`else
  assign merge_hit = 1'b0;
  assign st_ready  = ~full;
`endif

  assign acc      = st_valid & op_valid & st_ready & ~int_req & ~st_exc;
  assign enq      = acc & ~merge_hit;
  assign do_merge = acc & merge_hit;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged_data[gi*8 +: 8] = new_be[gi] ? new_data[gi*8 +: 8]
                                                : data_mem[tail_m1][gi*8 +: 8];
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PW-1:0] rel;
    assign rel     = PW'(gi) - head_reg;
    assign hit[gi] = ({1'b0, rel} < count_reg) &&
                     (((addr_mem[gi] ^ ld_addr) & WORD_MASK) == '0);
  end
  assign ld_conflict = |hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) tail_reg <= tail_reg + PW'(1);
      if (deq) head_reg <= head_reg + PW'(1);
      count_reg <= count_reg + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_reg] <= word_addr;
      be_mem[tail_reg]   <= new_be;
      data_mem[tail_reg] <= new_data;
    end else if (do_merge) begin
      be_mem[tail_m1]    <= be_mem[tail_m1] | new_be;
      data_mem[tail_m1]  <= merged_data;
    end
  end

  assign m_addr   = m_valid ? addr_mem[head_reg] : '0;
  assign m_byteen = m_valid ? be_mem[head_reg]   : '0;
  assign m_wdata  = m_valid ? data_mem[head_reg] : '0;
endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer: queue model checked every cycle on a 32-bit instance,
// plus directed literal checks on both a 32-bit and a 64-bit instance.
module tb_m_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [2:0] SB = 3'd1, SH = 3'd2, SW = 3'd3, SD = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        st_valid = 0, int_req = 0, m_ready = 0;
  logic [2:0]  st_op = 0;
  logic [31:0] st_addr = 0, st_wdata = 0, ld_addr = 0;
  logic        st_ready, st_exc, ld_conflict, m_valid, sb_empty;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_byteen;

  logic        v64 = 0, ir64 = 0, mr64 = 0;
  logic [2:0]  op64 = 0;
  logic [31:0] a64 = 0;
  logic [63:0] d64 = 0;
  logic        rdy64, exc64, conf64, mv64, empty64;
  logic [31:0] ma64;
  logic [7:0]  mbe64;
  logic [63:0] md64;

  m_store_buffer #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
    .st_wdata(st_wdata), .int_req(int_req), .st_ready(st_ready), .st_exc(st_exc),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .m_valid(m_valid), .m_addr(m_addr),
    .m_byteen(m_byteen), .m_wdata(m_wdata), .m_ready(m_ready), .sb_empty(sb_empty));

  m_store_buffer #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .reset(reset), .st_valid(v64), .st_op(op64), .st_addr(a64),
    .st_wdata(d64), .int_req(ir64), .st_ready(rdy64), .st_exc(exc64),
    .ld_addr(ld_addr), .ld_conflict(conf64), .m_valid(mv64), .m_addr(ma64),
    .m_byteen(mbe64), .m_wdata(md64), .m_ready(mr64), .sb_empty(empty64));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of pending memory writes.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];

  function automatic int op_size(logic [2:0] op);
    case (op)
      SB: return 1;
      SH: return 2;
      SW: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_exc();
    int sz = op_size(st_op);
    return st_valid && sz != 0 && (st_addr % sz) != 0;
  endfunction

  function automatic ent_t make_entry();
    ent_t e;
    int sz = op_size(st_op);
    e.addr = st_addr & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      e.data[i*8 +: 8] = st_wdata[(i % sz)*8 +: 8];
      e.be[i] = ((i / sz) == ((st_addr % 4) / sz));
    end
    return e;
  endfunction

  function automatic logic exp_merge(logic deq);
`ifdef M_SB_MERGE_EN
    if (q.size() == 0) return 1'b0;
    if (!(st_valid && op_size(st_op) != 0 && !int_req && !exp_exc())) return 1'b0;
    if (q[q.size()-1].addr != (st_addr & ~32'h3)) return 1'b0;
    return !(deq && q.size() == 1);
`else
    return 1'b0 & deq;
`endif
  endfunction

  function automatic logic exp_ready(logic deq);
    return (q.size() != DEPTH) || exp_merge(deq);
  endfunction

  function automatic logic exp_conflict();
    foreach (q[i]) if (q[i].addr == (ld_addr & ~32'h3)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      logic deq, mrg, acc;
      ent_t e, t;
      deq = (q.size() != 0) && m_ready;
      mrg = exp_merge(deq);
      acc = st_valid && op_size(st_op) != 0 && exp_ready(deq) && !int_req && !exp_exc();
      e = make_entry();
      if (acc && mrg) begin
        t = q[q.size()-1];
        for (int i = 0; i < 4; i++) if (e.be[i]) t.data[i*8 +: 8] = e.data[i*8 +: 8];
        t.be = t.be | e.be;
        q[q.size()-1] = t;
      end
      if (deq) void'(q.pop_front());
      if (acc && !mrg) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic deq;
      deq = (q.size() != 0) && m_ready;
      check("m_valid", m_valid, q.size() != 0);
      check("sb_empty", sb_empty, q.size() == 0);
      check("m_addr", m_addr, q.size() != 0 ? q[0].addr : 32'h0);
      check("m_byteen", m_byteen, q.size() != 0 ? q[0].be : 4'h0);
      check("m_wdata", m_wdata, q.size() != 0 ? q[0].data : 32'h0);
      check("st_ready", st_ready, exp_ready(deq));
      check("st_exc", st_exc, exp_exc());
      check("ld_conflict", ld_conflict, exp_conflict());
    end
  end

  task automatic drive(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] d, logic ir);
    st_valid = v; st_op = op; st_addr = a; st_wdata = d; int_req = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mixed traffic: {op, addr, data, int_req, m_ready}
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic        ir;
    logic        mr;
  } vec_t;
  vec_t vecs[10] = '{
    '{SB, 32'h5000, 32'h11, 1'b0, 1'b0},
    '{SB, 32'h5001, 32'h22, 1'b0, 1'b1},
    '{SH, 32'h5002, 32'h3344, 1'b0, 1'b0},
    '{SW, 32'h5004, 32'h55667788, 1'b0, 1'b1},
    '{SH, 32'h5001, 32'h9999, 1'b0, 1'b1},
    '{SB, 32'h5006, 32'hEE, 1'b1, 1'b0},
    '{SB, 32'h5006, 32'hEE, 1'b0, 1'b0},
    '{SH, 32'h5004, 32'hBEEF, 1'b0, 1'b1},
    '{SD, 32'h5008, 32'h12345678, 1'b0, 1'b1},
    '{SW, 32'h500C, 32'hCAFEF00D, 1'b0, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_st_ready", st_ready, 1);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_byteen", m_byteen, 0);
    check("rst_m_wdata", m_wdata, 0);
    tick();
    reset = 1'b0;

    // Byte then halfword into the same word
    drive(1, SB, 32'h1003, 32'hAB, 0); tick();
    drive(1, SH, 32'h1002, 32'h1234, 0); tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t1_head_addr", m_addr, 32'h1000);
`ifdef M_SB_MERGE_EN
    check("t1_head_be", m_byteen, 4'b1100);
    check("t1_head_data", m_wdata, 32'h1234ABAB);
`else
    check("t1_head_be", m_byteen, 4'b1000);
    check("t1_head_data", m_wdata, 32'hABABABAB);
`endif
    m_ready = 1; tick(); m_ready = 0;
    @(negedge clk);
`ifdef M_SB_MERGE_EN
    check("t1_empty", sb_empty, 1);
`else
    check("t1_e2_addr", m_addr, 32'h1000);
    check("t1_e2_be", m_byteen, 4'b1100);
    check("t1_e2_data", m_wdata, 32'h12341234);
`endif
    m_ready = 1; tick(); tick(); m_ready = 0;

    // Rejected stores
    drive(1, SW, 32'h2002, 32'hCAFEF00D, 0);
    @(negedge clk); check("t2_exc_mis", st_exc, 1);
    tick();
    drive(1, SW, 32'h2000, 32'h1, 1);
    @(negedge clk); check("t2_exc_int", st_exc, 0);
    tick();
    drive(1, SD, 32'h2008, 32'h2, 0);
    @(negedge clk); check("t2_exc_sd32", st_exc, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk); check("t2_empty", sb_empty, 1);

    // Fill to full, then drain
    m_ready = 0; ld_addr = 32'h3002;
    for (int i = 0; i < 4; i++) begin
      drive(1, SW, 32'h3000 + 32'(i*16), 32'hA0000000 + 32'(i), 0);
      tick();
    end
    drive(1, SW, 32'h3040, 32'hBBBBBBBB, 0); m_ready = 1;
    @(negedge clk);
    check("t3_full_ready", st_ready, 0);
    check("t3_conflict", ld_conflict, 1);
    check("t3_head0", m_addr, 32'h3000);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_ready_after_deq", st_ready, 1);
    check("t3_head1", m_addr, 32'h3010);
    check("t3_head1_data", m_wdata, 32'hA0000001);
    check("t3_no_conflict", ld_conflict, 0);
    tick(); tick(); tick();
    m_ready = 0;
    @(negedge clk); check("t3_drained", sb_empty, 1);

    // Mixed traffic against the model
    ld_addr = 32'h5004;
    foreach (vecs[i]) begin
      drive(1, vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].ir);
      m_ready = vecs[i].mr;
      tick();
    end
    drive(0, 0, 0, 0, 0); m_ready = 1;
    for (int i = 0; i < 8; i++) tick();

    // 64-bit port
    v64 = 1; op64 = SD; a64 = 32'h4008; d64 = 64'h1122334455667788; tick();
    op64 = SW; a64 = 32'h4004; d64 = 64'hDEADBEEF; tick();
    op64 = SD; a64 = 32'h4004;
    @(negedge clk);
    check("w64_exc_sd", exc64, 1);
    check("w64_valid", mv64, 1);
    check("w64_sd_addr", ma64, 32'h4008);
    check("w64_sd_be", mbe64, 8'hFF);
    check("w64_sd_data", md64, 64'h1122334455667788);
    tick();
    v64 = 0; mr64 = 1; tick(); mr64 = 0;
    @(negedge clk);
    check("w64_sw_addr", ma64, 32'h4000);
    check("w64_sw_be", mbe64, 8'hF0);
    check("w64_sw_data", md64, 64'hDEADBEEFDEADBEEF);
    mr64 = 1; tick(); mr64 = 0;
    @(negedge clk); check("w64_empty", empty64, 1);

    // Asynchronous reset with entries pending
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, SW, 32'h6000 + 32'(i*4), 32'h600D0000 + 32'(i), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_pending", m_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_empty", sb_empty, 1);
    check("t5_async_valid", m_valid, 0);
    check("t5_async_addr", m_addr, 0);
    tick();
    reset = 1'b0;
    @(negedge clk); check("t5_after", sb_empty, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/m_store_buffer.md
# m_store_buffer

Parametrised store-path unit for the MEM stage: converts a store op, address and register data into lane-replicated write data and a byte-enable mask, then queues the result in a DEPTH-entry FIFO. The FIFO drains to data memory through a valid/ready handshake, so the pipeline never waits on memory write latency. The block also suppresses stores that are interrupted or misaligned, and flags loads that alias a pending store.

## Interface
- DATA_W, 32: memory word width; 32 or 64. NB = DATA_W/8 lanes; OFF = log2(NB) offset bits.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- st_valid  in  1  MEM-stage store request.
- st_op  in  3  000 none, 001 SB, 010 SH, 011 SW, 100 SD. SD is legal only when DATA_W=64; otherwise it is treated as none.
- st_addr  in  32  byte address.
- st_wdata  in  DATA_W  source register data, right-aligned.
- int_req  in  1  interrupt or exception taken this cycle; cancels the store.
- st_ready  out  1  high when the FIFO is not full.
- st_exc  out  1  combinational misalignment flag (AdES).
- ld_addr  in  32  address of the load in MEM.
- ld_conflict  out  1  combinational; a valid entry has the same word address as ld_addr.
- m_valid  out  1  head entry is present.
- m_addr  out  32  head word address; low OFF bits are zero.
- m_byteen  out  NB  head byte enables.
- m_wdata  out  DATA_W  head data.
- m_ready  in  1  memory accepts the head entry.
- sb_empty  out  1  FIFO holds no entries.

## Operation
- Misalignment: SH with addr[0]≠0, SW with addr[1:0]≠0, SD with addr[2:0]≠0.
  - st_exc = st_valid & op≠none & misaligned; it is independent of int_req.
- Accept condition: `acc = st_valid & op≠none & st_ready & ~int_req & ~st_exc`. No FIFO state changes unless acc is high.
- Lane data is replicated across the full DATA_W:
  - SB: 8-bit data copied to every byte lane.
  - SH: 16-bit data copied to every halfword.
  - SW: 32-bit data copied to every word.
  - SD: data passed through unchanged.
- Byte enables:
  - SB: one-hot at addr[OFF-1:0].
  - SH: 2'b11 shifted left by addr[OFF-1:1]·2.
  - SW: 4'hF at lane 0 or lane 4 (by addr[2] when DATA_W=64).
  - SD: all lanes.
- Stored entry: {word address = st_addr with low OFF bits cleared, byteen, data}.
- FIFO pointers: head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Dequeue when m_valid & m_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- ld_conflict: OR over all valid entries of (entry word address == ld_addr word address). The ld_addr low OFF bits are ignored. The hazard unit stalls the load while ld_conflict is high.
- A store blocked because st_ready is low must be held by the pipeline (stall). This block does not retry it.

## Timing
- Reset values:
  - head, tail and count are 0.
  - m_valid = 0, sb_empty = 1, st_ready = 1.
  - m_addr, m_byteen and m_wdata are 0 while the FIFO is empty.
  - Entry storage needs no reset.
- Latency: an entry accepted at edge N drives m_valid=1 during cycle N+1. There is no combinational path from st_* to m_*.
- st_ready = (count≠DEPTH), computed from registered state only. When full it stays low even if m_ready is high that cycle.
- m_* outputs are stable while m_valid & ~m_ready.
- Empty with simultaneous accept: the entry enqueues; m_valid rises on the next cycle.
- Reset asserted mid-drain: all pending entries are discarded immediately (asynchronous).

## Configuration
- M_SB_MERGE_EN defined: store merging is enabled.
  - Condition: acc is high, count>0, the incoming word address equals the tail-1 entry's address, and that entry is not being dequeued this cycle (unless count≥2).
  - Effect: the store merges into that entry. Its byteen is ORed with the new byteen; enabled lanes are overwritten. Count and tail are unchanged.
  - Merge applies even when the FIFO is full, so st_ready = (count≠DEPTH) | merge_hit in this mode.
- M_SB_MERGE_EN undefined: every accepted store takes a new entry.

## Test plan
- DATA_W=32: SB 0x000000AB at 0x1003, then SH 0x1234 at 0x1002 → entries {0x1000, 4'b1000, 0xABABABAB} and {0x1000, 4'b1100, 0x12341234}. With merge enabled, a single entry {0x1000, 4'b1100, 0x1234ABAB} results.
- SW to 0x2002 → st_exc=1, no enqueue, count stays 0. SW to 0x2000 with int_req=1 → no enqueue.
- DEPTH=4, m_ready=0, 4 SWs to distinct words → st_ready=0 after the 4th. Then m_ready=1 → drains in order over 4 cycles, st_ready=1 after the first dequeue.
- Pending SW at 0x3000, ld_addr=0x3002 → ld_conflict=1. After drain, ld_conflict=0.
- DATA_W=64: SD at 0x4008 → m_byteen=8'hFF, m_addr=0x4008. SW at 0x4004 → byteen 8'hF0.
- Assert reset with 3 entries pending → sb_empty=1 and m_valid=0 immediately, without waiting for a clock edge.
